// File: rtl/sin_lut_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : sin_arb_pkg                                                    |
// | Purpose : Default sizing constants and helper functions shared by the    |
// |           sine-lookup arbiter, its bus interface and its tag FIFO.       |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package sin_arb_pkg;

  localparam int c_NREQ    = 4;   // number of requesters (2..8)
  localparam int c_PHASE_W = 10;  // lookup phase width
  localparam int c_SIN_W   = 16;  // sine sample width
  localparam int c_LUT_LAT = 2;   // lut_en -> lut_vld latency (>= 1)
  localparam int c_MAX_OUT = 4;   // outstanding lookups / tag FIFO depth

  // Width of a requester tag; never less than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sin_lut_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : sin_lut_arbiter_if                                           |
// | Purpose   : Bundles the requester-side and lookup-side bus signals of    |
// |             the shared sine-lookup arbiter.                              |
// | Signals   : req_valid/req_phase/req_ready - requester handshake          |
// |             rsp_valid/rsp_sin             - routed response              |
// |             lut_en/lut_phase              - issue to shared lookup       |
// |             lut_vld/lut_sin               - result from shared lookup    |
// | Modports  : master - the arbiter itself                                  |
// |             slave  - the surrounding clients and lookup datapath         |
// | Rev       : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
interface sin_lut_arbiter_if
  import sin_arb_pkg::*;
#(
  parameter int NREQ    = c_NREQ,
  parameter int PHASE_W = c_PHASE_W,
  parameter int SIN_W   = c_SIN_W
);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*PHASE_W-1:0] req_phase;
  logic [NREQ-1:0]         req_ready;
  logic                    lut_en;
  logic [PHASE_W-1:0]      lut_phase;
  logic                    lut_vld;
  logic [SIN_W-1:0]        lut_sin;
  logic [NREQ-1:0]         rsp_valid;
  logic [SIN_W-1:0]        rsp_sin;

  modport master (
    input  req_valid, req_phase, lut_vld, lut_sin,
    output req_ready, lut_en, lut_phase, rsp_valid, rsp_sin
  );

  modport slave (
    output req_valid, req_phase, lut_vld, lut_sin,
    input  req_ready, lut_en, lut_phase, rsp_valid, rsp_sin
  );

endinterface
`default_nettype wire

// File: rtl/sin_lut_arbiter_tag_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sin_arb_tag_fifo                                               |
// | Purpose : Synchronous circular FIFO holding the requester tag of every   |
// |           lookup in flight, so results can be routed back in order.      |
// |           Pointers wrap at DEPTH, which need not be a power of two.      |
// | Ports   : clk, rst_n (async, active-high)                                |
// |           push/din  - write a tag (ignored when full)                    |
// |           pop/dout  - dout shows the head; pop removes it (ignored when  |
// |                       empty)                                             |
// |           count, empty, full - occupancy status                          |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sin_arb_tag_fifo
  import sin_arb_pkg::*;
#(
  parameter int DEPTH = c_MAX_OUT,
  parameter int WIDTH = tag_w(c_NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_CNT_W'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sin_lut_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sin_lut_arbiter                                                |
// | Purpose : Shares one sine-lookup datapath among NREQ requesters. A       |
// |           round-robin arbiter issues at most one lookup per cycle, tags  |
// |           it with the requester index and routes each result back to its |
// |           originator in issue order.                                     |
// | Ports   : clk        - clock                                             |
// |           rst_n      - reset, asynchronous, active-high                  |
// |           bus        - sin_lut_arbiter_if.master (requests, responses,   |
// |                        lookup issue and lookup result)                   |
// |           busy       - lookups outstanding or being issued               |
// |           err_orphan - sticky: a lookup result arrived with no tag       |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sin_lut_arbiter
  import sin_arb_pkg::*;
#(
  parameter int NREQ    = c_NREQ,
  parameter int PHASE_W = c_PHASE_W,
  parameter int SIN_W   = c_SIN_W,
  parameter int LUT_LAT = c_LUT_LAT,
  parameter int MAX_OUT = c_MAX_OUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sin_lut_arbiter_if.master       bus,
  output logic                    busy,
  output logic                    err_orphan
);

  localparam int c_TAG_W   = tag_w(NREQ);
  localparam int c_CNT_W   = $clog2(MAX_OUT + 1);
  localparam int c_QUIET_W = $clog2(LUT_LAT + 2);
  localparam logic [c_QUIET_W-1:0] c_QUIET_INIT = c_QUIET_W'(LUT_LAT + 1);

  // Registered state
  logic [c_QUIET_W-1:0] r_quiet;
  logic [c_TAG_W-1:0]   r_ptr;
  logic                 r_lut_en;
  logic [PHASE_W-1:0]   r_lut_phase;
  logic [NREQ-1:0]      r_rsp_valid;
  logic [SIN_W-1:0]     r_rsp_sin;
  logic                 r_err_orphan;

  // Combinational
  logic                 w_quiet;
  logic                 w_eligible;
  logic [NREQ-1:0]      w_grant_vec;
  logic [c_TAG_W-1:0]   w_grant_idx;
  logic [c_TAG_W-1:0]   w_cand;
  logic                 w_found;
  logic [PHASE_W-1:0]   w_grant_phase;
  logic                 w_pop;
  logic                 w_orphan;
  logic [c_TAG_W-1:0]   w_tag_head;
  logic [c_CNT_W-1:0]   w_count;
  logic                 w_empty;
  logic                 w_full;

  // ------------------------------------------------------------------------
  // Quiet window: after reset release, lookups issued before the reset may
  // still emerge from the shared datapath. Hold off grants and swallow any
  // lut_vld for LUT_LAT+1 cycles so those stale results are flushed.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_quiet <= c_QUIET_INIT;
    end else if (r_quiet != '0) begin
      r_quiet <= r_quiet - 1'b1;
    end
  end

  assign w_quiet = (r_quiet != '0);

  // Eligibility uses the registered occupancy; a pop in the same cycle does
  // not free a slot until the next cycle. The occupancy includes the lookup
  // sitting in the issue register, since its tag is pushed at the handshake.
  assign w_eligible = !w_quiet && !w_full;

  // ------------------------------------------------------------------------
  // Round-robin search starting one past the last granted requester.
  // ------------------------------------------------------------------------
  always_comb begin
    w_grant_vec = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = c_TAG_W'((int'(r_ptr) + k) % NREQ);
      if (w_eligible && !w_found && bus.req_valid[w_cand]) begin
        w_found             = 1'b1;
        w_grant_idx         = w_cand;
        w_grant_vec[w_cand] = 1'b1;
      end
    end
  end

  // Phase of the granted requester (one-hot select).
  always_comb begin
    w_grant_phase = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_vec[i]) begin
        w_grant_phase = bus.req_phase[i*PHASE_W +: PHASE_W];
      end
    end
  end

  // Grants are only raised where req_valid is set, so a found grant is a
  // completed handshake.
  assign bus.req_ready = w_grant_vec;

  // ------------------------------------------------------------------------
  // Tag FIFO: one entry per lookup in flight, popped as results return.
  // ------------------------------------------------------------------------
  assign w_pop    = bus.lut_vld && !w_quiet && !w_empty;
  assign w_orphan = bus.lut_vld && !w_quiet && w_empty;

  sin_arb_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (c_TAG_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_found),
    .pop   (w_pop),
    .din   (w_grant_idx),
    .dout  (w_tag_head),
    .count (w_count),
    .empty (w_empty),
    .full  (w_full)
  );

  // ------------------------------------------------------------------------
  // Issue register, response register and sticky orphan flag.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ptr        <= c_TAG_W'(NREQ - 1);
      r_lut_en     <= 1'b0;
      r_lut_phase  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_sin    <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_lut_en <= w_found;
      if (w_found) begin
        r_lut_phase <= w_grant_phase;
        r_ptr       <= w_grant_idx;
      end
      r_rsp_valid <= w_pop ? (NREQ'(1) << w_tag_head) : '0;
      if (w_pop) begin
        r_rsp_sin <= bus.lut_sin;
      end
      if (w_orphan) begin
        r_err_orphan <= 1'b1;
      end
    end
  end

  assign bus.lut_en    = r_lut_en;
  assign bus.lut_phase = r_lut_phase;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_sin   = r_rsp_sin;
  assign busy          = (w_count != '0) || r_lut_en;
  assign err_orphan    = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_sin_lut_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sin_lut_arbiter                                             |
// | Purpose : Directed self-checking bench for sin_lut_arbiter. The shared   |
// |           lookup is a LUT_LAT=2 pipeline returning {6'b0,phase}+16'h1000 |
// |           with an optional stall that holds results back.                |
// | Ports   : none (top-level bench)                                         |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sin_lut_arbiter;
  import sin_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int PHASE_W = 10;
  localparam int SIN_W   = 16;
  localparam int LUT_LAT = 2;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic err_orphan;

  int n_checks = 0;
  int n_err    = 0;

  sin_lut_arbiter_if #(.NREQ(NREQ), .PHASE_W(PHASE_W), .SIN_W(SIN_W)) bus ();

  sin_lut_arbiter #(
    .NREQ    (NREQ),
    .PHASE_W (PHASE_W),
    .SIN_W   (SIN_W),
    .LUT_LAT (LUT_LAT),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  // Lookup model: results due LUT_LAT cycles after lut_en, one per cycle,
  // held back while stall is set. It ignores the arbiter reset on purpose.
  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    int                 due;
  } lk_t;

  lk_t              mdl_q[$];
  logic             mdl_vld   = 1'b0;
  logic [SIN_W-1:0] mdl_sin   = '0;
  logic             stall     = 1'b0;
  logic             force_vld = 1'b0;

  assign bus.lut_vld = mdl_vld | force_vld;
  assign bus.lut_sin = mdl_sin;

  initial begin
    int  cyc;
    lk_t e;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (bus.lut_en) begin
        e.phase = bus.lut_phase;
        e.due   = cyc + LUT_LAT - 1;
        mdl_q.push_back(e);
      end
      if (!stall && mdl_q.size() > 0 && mdl_q[0].due <= cyc) begin
        mdl_vld <= 1'b1;
        mdl_sin <= {6'b0, mdl_q[0].phase} + 16'h1000;
        void'(mdl_q.pop_front());
      end else begin
        mdl_vld <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_req_ready"},  32'(bus.req_ready), 0);
    chk({pfx, "_lut_en"},     32'(bus.lut_en),    0);
    chk({pfx, "_lut_phase"},  32'(bus.lut_phase), 0);
    chk({pfx, "_rsp_valid"},  32'(bus.rsp_valid), 0);
    chk({pfx, "_rsp_sin"},    32'(bus.rsp_sin),   0);
    chk({pfx, "_busy"},       32'(busy),          0);
    chk({pfx, "_err_orphan"}, 32'(err_orphan),    0);
  endtask

  task automatic set_phases(input logic [9:0] p0, input logic [9:0] p1,
                            input logic [9:0] p2, input logic [9:0] p3);
    bus.req_phase = {p3, p2, p1, p0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.req_phase = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");

    // Quiet window, then round-robin with all requesters active
    @(negedge clk);
    rst_n = 1'b0;
    set_phases(10'd1, 10'd2, 10'd3, 10'd4);
    bus.req_valid = 4'hF;
    #1;
    chk("rr_quiet0_ready", 32'(bus.req_ready), 0);
    for (int q = 1; q < 3; q++) begin
      @(negedge clk);
      #1;
      chk("rr_quiet_ready", 32'(bus.req_ready), 0);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid = (k < 6) ? 4'hF : 4'h0;
      #1;
      chk("rr_ready", 32'(bus.req_ready), (k < 6) ? (1 << (k % 4)) : 0);
      chk("rr_lut_en", 32'(bus.lut_en), (k >= 1 && k <= 6) ? 1 : 0);
      if (k >= 1 && k <= 6) chk("rr_lut_phase", 32'(bus.lut_phase), ((k - 1) % 4) + 1);
      chk("rr_rsp_valid", 32'(bus.rsp_valid), (k >= 4) ? (1 << ((k - 4) % 4)) : 0);
      if (k >= 4) chk("rr_rsp_sin", 32'(bus.rsp_sin), 32'h1001 + ((k - 4) % 4));
    end
    @(negedge clk);
    #1;
    chk("rr_end_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rr_end_busy", 32'(busy), 0);

    // Single request from requester 1
    @(negedge clk);
    set_phases(10'd0, 10'd100, 10'd0, 10'd0);
    bus.req_valid = 4'b0010;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk("single_lut_en", 32'(bus.lut_en), 1);
    chk("single_lut_phase", 32'(bus.lut_phase), 100);
    chk("single_ready_off", 32'(bus.req_ready), 0);
    chk("single_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("single_lut_en_off", 32'(bus.lut_en), 0);
    chk("single_lut_phase_hold", 32'(bus.lut_phase), 100);
    @(negedge clk);
    #1;
    chk("single_rsp_early", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    #1;
    chk("single_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
    chk("single_rsp_sin", 32'(bus.rsp_sin), 32'h1064);
    @(negedge clk);
    #1;
    chk("single_rsp_done", 32'(bus.rsp_valid), 0);
    chk("single_busy_done", 32'(busy), 0);

    // Backpressure: results stalled, four outstanding fill the tag FIFO
    set_phases(10'd1, 10'd2, 10'd3, 10'd4);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      bus.req_valid = (k <= 12) ? 4'hF : 4'h0;
      stall = (k < 10);
      #1;
      if (k < 4)
        chk("bp_ready", 32'(bus.req_ready), 1 << ((k + 2) % 4));
      else if (k == 12)
        chk("bp_ready_reenable", 32'(bus.req_ready), 32'b0100);
      else
        chk("bp_ready_blocked", 32'(bus.req_ready), 0);
      chk("bp_busy", 32'(busy), (k >= 1 && k <= 15) ? 1 : 0);
      if (k >= 12 && k <= 15) begin
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 1 << ((k - 10) % 4));
        chk("bp_rsp_sin", 32'(bus.rsp_sin), 32'h1001 + ((k - 10) % 4));
      end else if (k == 16) begin
        chk("bp_rsp_valid_last", 32'(bus.rsp_valid), 32'b0100);
        chk("bp_rsp_sin_last", 32'(bus.rsp_sin), 32'h1003);
      end else begin
        chk("bp_rsp_idle", 32'(bus.rsp_valid), 0);
      end
    end
    chk("bp_err_orphan", 32'(err_orphan), 0);

    // Orphan result with nothing outstanding
    @(negedge clk);
    force_vld = 1'b1;
    #1;
    chk("orphan_before", 32'(err_orphan), 0);
    @(negedge clk);
    force_vld = 1'b0;
    #1;
    chk("orphan_set", 32'(err_orphan), 1);
    chk("orphan_rsp", 32'(bus.rsp_valid), 0);
    repeat (2) @(negedge clk);
    #1;
    chk("orphan_sticky", 32'(err_orphan), 1);
    chk("orphan_rsp_later", 32'(bus.rsp_valid), 0);

    // Reset with three lookups in flight (held in the stalled model)
    set_phases(10'h3FF, 10'd6, 10'd7, 10'd8);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 4'hF;
    end
    @(negedge clk);
    bus.req_valid = 4'h0;
    #1;
    chk("mid_busy", 32'(busy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    chk_reset_outs("mid_rst_a");
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk_reset_outs("mid_rst_b");
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    for (int q = 0; q < 3; q++) begin
      if (q > 0) begin
        @(negedge clk);
        #1;
      end
      chk("post_quiet_ready", 32'(bus.req_ready), 0);
      chk("post_quiet_err", 32'(err_orphan), 0);
      chk("post_quiet_rsp", 32'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    #1;
    chk("post_ready", 32'(bus.req_ready), 32'b0001);
    chk("post_err", 32'(err_orphan), 0);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    chk("post_lut_en", 32'(bus.lut_en), 1);
    chk("post_lut_phase", 32'(bus.lut_phase), 32'h3FF);
    repeat (2) @(negedge clk);
    #1;
    chk("post_rsp_early", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    #1;
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
    chk("post_rsp_sin", 32'(bus.rsp_sin), 32'h13FF);
    @(negedge clk);
    #1;
    chk("post_rsp_done", 32'(bus.rsp_valid), 0);
    chk("post_busy_done", 32'(busy), 0);
    chk("post_err_done", 32'(err_orphan), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sin_lut_arbiter.md
Name: sin_lut_arbiter

Overview:
- Shares one sine-lookup datapath among NREQ independent requesters.
- The datapath takes phase + enable and returns a valid-qualified sine sample a fixed number of cycles later.
- Round-robin arbitration issues at most one lookup per cycle and tags each one with the requester index. Results are routed back to the originating requester in issue order.
- Sits between DDS/modulator clients and the single shared sine-lookup instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PHASE_W, 10, phase width sent to the lookup.
- SIN_W, 16, sine sample width.
- LUT_LAT, 2, lookup latency in cycles from lut_en to lut_vld (≥1).
- MAX_OUT, 4, maximum outstanding lookups; tag FIFO depth (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester lookup request.
- req_phase  in  NREQ*PHASE_W  packed phases; requester i occupies bits [i*PHASE_W +: PHASE_W].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- lut_en  out  1  lookup enable to the shared datapath.
- lut_phase  out  PHASE_W  lookup phase.
- lut_vld  in  1  lookup result valid.
- lut_sin  in  SIN_W  lookup result.
- rsp_valid  out  NREQ  one-hot response strobe.
- rsp_sin  out  SIN_W  response sample; meaningful only while rsp_valid != 0.
- busy  out  1  high when outstanding != 0 or lut_en = 1.
- err_orphan  out  1  sticky: lut_vld was seen with no outstanding tag.

Behaviour:
- Reset: rst_n is asynchronous and active-high (reset while rst_n = 1).
  - Reset values: req_ready = 0, lut_en = 0, lut_phase = 0, rsp_valid = 0, rsp_sin = 0, busy = 0, err_orphan = 0.
  - Tag FIFO emptied, RR pointer = NREQ-1, so requester 0 has first priority.
- Quiet window after reset release:
  - A counter holds the block quiet for LUT_LAT+1 cycles.
  - During this window: no grants (req_ready = 0), and any lut_vld is discarded silently without setting err_orphan. This flushes lookups that were in flight when reset hit mid-operation.
- Arbitration (combinational from registered state):
  - Eligible when the quiet window is over and outstanding < MAX_OUT.
  - Search begins at ptr+1 (mod NREQ); the first requester with req_valid = 1 gets req_ready = 1. At most one bit is set.
  - req_ready may depend on req_valid. A requester must not make req_valid depend on req_ready.
- Handshake at posedge when valid & ready:
  - Next cycle: lut_en = 1 and lut_phase = the granted phase (1-cycle issue latency).
  - Granted index pushed to the tag FIFO; ptr = granted index.
  - If there is no handshake: lut_en = 0 and lut_phase holds its value.
- Throughput: back-to-back issue, one per cycle, while outstanding < MAX_OUT.
  - outstanding counts pushes minus pops; the count includes lookups still in the issue register.
- Response path on lut_vld = 1 (after the quiet window):
  - FIFO non-empty: pop the head tag t; next cycle rsp_valid = 1<<t and rsp_sin = lut_sin (1-cycle response latency). Otherwise rsp_valid = 0.
  - FIFO empty: drop the result and set err_orphan = 1 (cleared only by reset).
- Simultaneous push and pop in the same cycle: outstanding unchanged; both operations take effect. With MAX_OUT outstanding, a pop in the same cycle does NOT enable a grant; grant eligibility uses the registered count.
- Total latency, handshake to rsp_valid: LUT_LAT+2 cycles.
- Ordering: responses return strictly in issue order. Fairness: a continuously requesting client waits at most NREQ-1 grants.
- Tag FIFO: circular buffer of MAX_OUT entries, each $clog2(NREQ) bits wide. Read and write pointers wrap at MAX_OUT, not at a power of 2.

Decomposition:
- Package sin_arb_pkg: default constants (NREQ, PHASE_W, SIN_W, LUT_LAT, MAX_OUT) and the tag width function TAG_W = $clog2(NREQ) (min 1).
- One sub-module: sin_arb_tag_fifo (synchronous FIFO, MAX_OUT deep). Ports: push, pop, din, dout, count, empty, full.
- Round-robin search stays inline in the top level.

Test Plan:
- Bench model: the lookup is modelled as a LUT_LAT=2 pipeline returning lut_sin = {6'b0, phase} + 16'h1000. Defaults are used.
- Single request: req_valid = 4'b0010, phase1 = 10'd100 after the quiet window.
  - req_ready = 4'b0010 in the same cycle; lut_en pulses once with lut_phase = 100.
  - 4 cycles after the handshake: rsp_valid = 4'b0010, rsp_sin = 16'h1064.
- Round-robin: all 4 requesters held valid with phases 1, 2, 3, 4.
  - Grant order 0, 1, 2, 3, 0, ...
  - Responses in the same order with rsp_sin = 16'h1001, 16'h1002, 16'h1003, 16'h1004; one per cycle after the 4-cycle fill.
- Backpressure: MAX_OUT = 4 and the model stalls lut_vld 10 cycles.
  - After 4 grants req_ready = 0 and busy = 1.
  - The first response pop re-enables grants the following cycle; no response is lost or reordered.
- Orphan: after the quiet window the bench forces lut_vld = 1 with nothing outstanding.
  - err_orphan = 1 and stays set; rsp_valid stays 0.
- Mid-operation reset: assert rst_n = 1 with 3 lookups outstanding while the model keeps returning lut_vld for 2 cycles.
  - All outputs are at reset values while rst_n = 1.
  - After release: no grants for 3 cycles, the stale lut_vld is dropped, err_orphan = 0.
  - A subsequent request to requester 0 completes normally.
